// File: rtl/ic_test_sequencer.sv
// Vector-driven functional test sequencer for 74xx logic ICs selected by keyboard part number.
// Optional build macro STOP_ON_FAIL_EN: end the test at the first mismatching vector.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no test, pins released, waiting for an ic_read rising edge
// DECODE   | map ic_code to a ROM bank or flag it unsupported
// FETCH    | vec_addr presents {bank, idx} to the vector ROM
// WAIT_ROM | ROM data valid, captured into the vector registers
// APPLY    | captured drive/enable values moved onto the pins
// SETTLE   | down-count settle timer until terminal count
// SAMPLE   | compare pin_in to expected levels under the mask
// DONE     | result held, pins released, waiting for a new start
module ic_test_sequencer #(
  parameter int NUM_PINS      = 14,
  parameter int VEC_AW        = 4,
  parameter int SETTLE_CYCLES = 50
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  ic_read,
  input  logic [15:0]           ic_code,
  input  logic                  abort,
  output logic [VEC_AW+2:0]     vec_addr,
  input  logic [NUM_PINS-1:0]   vec_drive,
  input  logic [NUM_PINS-1:0]   vec_oe,
  input  logic [NUM_PINS-1:0]   vec_expect,
  input  logic [NUM_PINS-1:0]   vec_mask,
  input  logic                  vec_last,
  output logic [NUM_PINS-1:0]   pin_out,
  output logic [NUM_PINS-1:0]   pin_oe,
  input  logic [NUM_PINS-1:0]   pin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  unsupported,
  output logic [VEC_AW-1:0]     fail_index
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, DECODE, FETCH, WAIT_ROM, APPLY, SETTLE, SAMPLE, DONE
  } state_t;

  state_t                state, state_n;
  logic                  ic_read_q;
  logic [2:0]            bank, bank_n;
  logic [VEC_AW-1:0]     idx, idx_n, idx_inc;
  logic                  fail_flag, fail_flag_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [NUM_PINS-1:0]   cap_drive, cap_drive_n, cap_oe, cap_oe_n;
  logic [NUM_PINS-1:0]   cap_expect, cap_expect_n, cap_mask, cap_mask_n;
  logic                  cap_last, cap_last_n;
  logic [VEC_AW+2:0]     vec_addr_n;
  logic [NUM_PINS-1:0]   pin_out_n, pin_oe_n;
  logic                  busy_n, done_n, pass_n, unsupported_n;
  logic [VEC_AW-1:0]     fail_index_n;
  logic                  start, code_ok, mismatch, finish;
  logic [2:0]            code_bank;

  assign start    = ic_read & ~ic_read_q;
  assign idx_inc  = idx + VEC_AW'(1);
  assign mismatch = |((pin_in ^ cap_expect) & cap_mask);

  always_comb begin
    code_ok   = 1'b1;
    code_bank = 3'd0;
    case (ic_code)
      16'h7400: code_bank = 3'd0;
      16'h7402: code_bank = 3'd1;
      16'h7404: code_bank = 3'd2;
      16'h7408: code_bank = 3'd3;
      16'h7432: code_bank = 3'd4;
      16'h7486: code_bank = 3'd5;
      default:  code_ok   = 1'b0;
    endcase
  end

  always_comb begin
    state_n       = state;
    bank_n        = bank;
    idx_n         = idx;
    fail_flag_n   = fail_flag;
    cnt_n         = cnt;
    cap_drive_n   = cap_drive;
    cap_oe_n      = cap_oe;
    cap_expect_n  = cap_expect;
    cap_mask_n    = cap_mask;
    cap_last_n    = cap_last;
    vec_addr_n    = vec_addr;
    pin_out_n     = pin_out;
    pin_oe_n      = pin_oe;
    busy_n        = busy;
    done_n        = done;
    pass_n        = pass;
    unsupported_n = unsupported;
    fail_index_n  = fail_index;
    finish        = cap_last | (&idx);
`ifdef STOP_ON_FAIL_EN
    finish        = finish | mismatch;
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n       = DECODE;
          busy_n        = 1'b1;
          done_n        = 1'b0;
          pass_n        = 1'b0;
          unsupported_n = 1'b0;
          fail_index_n  = '0;
        end
      end
      DECODE: begin
        if (!code_ok) begin
          state_n       = DONE;
          busy_n        = 1'b0;
          done_n        = 1'b1;
          unsupported_n = 1'b1;
          pass_n        = 1'b0;
          pin_oe_n      = '0;
        end else begin
          state_n     = FETCH;
          bank_n      = code_bank;
          idx_n       = '0;
          fail_flag_n = 1'b0;
          vec_addr_n  = {code_bank, {VEC_AW{1'b0}}};
        end
      end
      FETCH: state_n = WAIT_ROM;
      WAIT_ROM: begin
        cap_drive_n  = vec_drive;
        cap_oe_n     = vec_oe;
        cap_expect_n = vec_expect;
        cap_mask_n   = vec_mask;
        cap_last_n   = vec_last;
        state_n      = APPLY;
      end
      APPLY: begin
        pin_out_n = cap_drive;
        pin_oe_n  = cap_oe;
        cnt_n     = CNT_W'(SETTLE_CYCLES - 1);
        state_n   = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) state_n = SAMPLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      SAMPLE: begin
        if (mismatch && !fail_flag) begin
          fail_index_n = idx;
          fail_flag_n  = 1'b1;
        end
        if (finish) begin
          state_n  = DONE;
          busy_n   = 1'b0;
          done_n   = 1'b1;
          pass_n   = ~(fail_flag | mismatch);
          pin_oe_n = '0;
        end else begin
          state_n    = FETCH;
          idx_n      = idx_inc;
          vec_addr_n = {bank, idx_inc};
        end
      end
      default: state_n = IDLE;
    endcase

    // abort outranks any start or progress decided above
    if (abort) begin
      state_n       = IDLE;
      pin_oe_n      = '0;
      busy_n        = 1'b0;
      done_n        = 1'b0;
      pass_n        = 1'b0;
      unsupported_n = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= IDLE;
      ic_read_q   <= 1'b0;
      bank        <= '0;
      idx         <= '0;
      fail_flag   <= 1'b0;
      cnt         <= '0;
      cap_drive   <= '0;
      cap_oe      <= '0;
      cap_expect  <= '0;
      cap_mask    <= '0;
      cap_last    <= 1'b0;
      vec_addr    <= '0;
      pin_out     <= '0;
      pin_oe      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      unsupported <= 1'b0;
      fail_index  <= '0;
    end else begin
      state       <= state_n;
      ic_read_q   <= ic_read;
      bank        <= bank_n;
      idx         <= idx_n;
      fail_flag   <= fail_flag_n;
      cnt         <= cnt_n;
      cap_drive   <= cap_drive_n;
      cap_oe      <= cap_oe_n;
      cap_expect  <= cap_expect_n;
      cap_mask    <= cap_mask_n;
      cap_last    <= cap_last_n;
      vec_addr    <= vec_addr_n;
      pin_out     <= pin_out_n;
      pin_oe      <= pin_oe_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      unsupported <= unsupported_n;
      fail_index  <= fail_index_n;
    end
  end

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Bench for ic_test_sequencer: randomized vector banks checked against a per-test result/timing model.
module tb_ic_test_sequencer;
  localparam int NP = 14;
  localparam int AW = 4;
  localparam int S  = 4;
  localparam int VC = S + 4;

  logic            iCLK = 1'b0;
  logic            iRST, ic_read, abort;
  logic [15:0]     ic_code;
  logic [AW+2:0]   vec_addr;
  logic [NP-1:0]   vec_drive, vec_oe, vec_expect, vec_mask;
  logic            vec_last;
  logic [NP-1:0]   pin_out, pin_oe, pin_in;
  logic            busy, done, pass, unsupported;
  logic [AW-1:0]   fail_index;

  logic [NP-1:0]   rom_drive [128];
  logic [NP-1:0]   rom_oe    [128];
  logic [NP-1:0]   rom_exp   [128];
  logic [NP-1:0]   rom_mask  [128];
  logic            rom_last  [128];
  logic [NP-1:0]   resp      [128];
  logic [15:0]     codes     [6];

  int n_checks = 0;
  int n_fail   = 0;

  ic_test_sequencer #(.NUM_PINS(NP), .VEC_AW(AW), .SETTLE_CYCLES(S)) dut (
    .iCLK(iCLK), .iRST(iRST), .ic_read(ic_read), .ic_code(ic_code), .abort(abort),
    .vec_addr(vec_addr), .vec_drive(vec_drive), .vec_oe(vec_oe), .vec_expect(vec_expect),
    .vec_mask(vec_mask), .vec_last(vec_last), .pin_out(pin_out), .pin_oe(pin_oe),
    .pin_in(pin_in), .busy(busy), .done(done), .pass(pass), .unsupported(unsupported),
    .fail_index(fail_index)
  );

  always #5 iCLK = ~iCLK;

  // synchronous vector ROM with one cycle of read latency
  always @(posedge iCLK) begin
    vec_drive  <= rom_drive[vec_addr];
    vec_oe     <= rom_oe[vec_addr];
    vec_expect <= rom_exp[vec_addr];
    vec_mask   <= rom_mask[vec_addr];
    vec_last   <= rom_last[vec_addr];
  end

  // the IC in the socket answers the vector currently addressed
  assign pin_in = resp[vec_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_bank(input int b, input int nvec, input bit has_last, input logic [15:0] faults);
    for (int i = 0; i < 16; i++) begin
      int a;
      logic [NP-1:0] m, r;
      a = b * 16 + i;
      rom_drive[a] = NP'($urandom);
      rom_oe[a]    = NP'($urandom);
      rom_exp[a]   = NP'($urandom);
      m = NP'($urandom) | (NP'(1) << $urandom_range(0, NP - 1));
      rom_mask[a]  = m;
      rom_last[a]  = has_last && (i == nvec - 1);
      r = rom_exp[a] ^ (NP'($urandom) & ~m);
      if (faults[i]) r = r ^ (m & (~m + NP'(1)));
      resp[a] = r;
    end
  endtask

  task automatic start_test(input logic [15:0] code);
    @(negedge iCLK);
    ic_code = code;
    ic_read = 1'b0;
    @(negedge iCLK);
    ic_read = 1'b1;
    @(posedge iCLK);
    #1;
  endtask

  task automatic run_test(input logic [15:0] code);
    int b, n, ff, nrun, exp_c, c, max_idx;
    bit sup, got_done;
    logic [AW+2:0] addr_before;
    sup = 0;
    b = 0;
    for (int k = 0; k < 6; k++) if (code == codes[k]) begin sup = 1; b = k; end
    n = 16;
    for (int i = 15; i >= 0; i--) if (rom_last[b * 16 + i]) n = i + 1;
    ff = -1;
    for (int i = 0; i < n; i++)
      if (ff < 0 && ((resp[b * 16 + i] ^ rom_exp[b * 16 + i]) & rom_mask[b * 16 + i]) != 0) ff = i;
    nrun = n;
`ifdef STOP_ON_FAIL_EN
    if (ff >= 0) nrun = ff + 1;
`endif
    exp_c = sup ? 1 + nrun * VC : 1;
    addr_before = vec_addr;
    start_test(code);
    check("busy_at_start", busy, 1);
    check("done_cleared", done, 0);
    c = 0;
    got_done = 0;
    max_idx = -1;
    while (!got_done && c < exp_c + 20) begin
      @(posedge iCLK);
      #1;
      c++;
      if (sup) begin
        if (int'(vec_addr[AW-1:0]) > max_idx) max_idx = int'(vec_addr[AW-1:0]);
        for (int v = 0; v < nrun; v++) begin
          if (c == 1 + v * VC) check("vec_addr_step", vec_addr, b * 16 + v);
          if (c == 4 + v * VC) begin
            check("pin_out_apply", pin_out, rom_drive[b * 16 + v]);
            check("pin_oe_apply", pin_oe, rom_oe[b * 16 + v]);
          end
        end
      end else begin
        check("unsup_pin_oe", pin_oe, 0);
      end
      if (done) got_done = 1;
    end
    check("done_seen", got_done, 1);
    check("done_cycle", c, exp_c);
    check("pass", pass, sup && ff < 0);
    check("unsupported", unsupported, !sup);
    check("fail_index", fail_index, (sup && ff >= 0) ? ff : 0);
    check("done_pin_oe", pin_oe, 0);
    check("done_busy", busy, 0);
    if (sup) check("last_index", max_idx, nrun - 1);
    else     check("unsup_vec_addr", vec_addr, addr_before);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec_addr"}, vec_addr, 0);
    check({tag, "_pin_out"}, pin_out, 0);
    check({tag, "_pin_oe"}, pin_oe, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_unsup"}, unsupported, 0);
    check({tag, "_fail_index"}, fail_index, 0);
  endtask

  initial begin
    codes = '{16'h7400, 16'h7402, 16'h7404, 16'h7408, 16'h7432, 16'h7486};
    for (int i = 0; i < 128; i++) begin
      rom_drive[i] = '0; rom_oe[i] = '0; rom_exp[i] = '0;
      rom_mask[i] = '0; rom_last[i] = 1'b0; resp[i] = '0;
    end
    iRST = 1'b1; ic_read = 1'b0; abort = 1'b0; ic_code = 16'h0;
    repeat (3) @(posedge iCLK);
    #1;
    check_all_zero("reset");
    @(negedge iCLK);
    iRST = 1'b0;

    fill_bank(0, 4, 1, 16'h0000);
    run_test(16'h7400);
    fill_bank(3, 4, 1, 16'b1100);
    run_test(16'h7408);
    run_test(16'h7499);
    fill_bank(1, 4, 1, 16'b1010);
    run_test(16'h7402);

    // abort during the settle window of vector 1, then restart from vector 0
    fill_bank(0, 4, 1, 16'h0000);
    start_test(16'h7400);
    repeat (1 + VC + 3) @(posedge iCLK);
    @(negedge iCLK);
    abort = 1'b1;
    @(posedge iCLK);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pin_oe", pin_oe, 0);
    @(negedge iCLK);
    abort = 1'b0;
    run_test(16'h7400);

    // ic_read held high after completion must not retrigger
    repeat (100) @(posedge iCLK);
    #1;
    check("hold_busy", busy, 0);
    check("hold_done", done, 1);
    check("hold_vec_addr", vec_addr, 3);
    fill_bank(5, 16, 0, 16'h0000);
    run_test(16'h7486);

    // reset in the middle of a test
    fill_bank(2, 6, 1, 16'h0010);
    start_test(16'h7404);
    repeat (10) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    check_all_zero("midreset");
    @(negedge iCLK);
    ic_read = 1'b0;
    iRST = 1'b0;
    run_test(16'h7404);

    for (int t = 0; t < 25; t++) begin
      int k;
      logic [15:0] code;
      k = $urandom_range(0, 6);
      if (k == 6) begin
        code = 16'h7400;
        while (code == 16'h7400 || code == 16'h7402 || code == 16'h7404 ||
               code == 16'h7408 || code == 16'h7432 || code == 16'h7486)
          code = 16'($urandom);
      end else begin
        code = codes[k];
        fill_bank(k, $urandom_range(1, 16), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) ? 16'($urandom & $urandom) : 16'h0);
      end
      run_test(code);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ic_test_sequencer.md
Name: ic_test_sequencer

Overview:
- Runs the functional test of the IC whose 4-digit part number was entered on the keyboard and latched by the digit-entry state machine.
- On a rising edge of the entry-complete flag, decodes the part number to a vector-ROM bank, then steps through its vectors: drive DUT pins, wait to settle, sample, compare.
- Reports pass/fail and the first failing vector index to the display/result logic.

Parameters:
- NUM_PINS, 14, DUT socket pin count (width of pin buses).
- VEC_AW, 4, vector index width; max 2^VEC_AW vectors per part.
- SETTLE_CYCLES, 50, iCLK cycles between driving pins and sampling (>=1).

Ports:
- iCLK  input  1  system clock
- iRST  input  1  synchronous active-high reset
- ic_read  input  1  level flag from digit-entry FSM; rising edge starts a test
- ic_code  input  16  entered part number, one hex digit per nibble (e.g. 16'h7400)
- abort  input  1  synchronous abort (return key); returns to IDLE
- vec_addr  output  3+VEC_AW  vector ROM address {bank[2:0], index}
- vec_drive  input  NUM_PINS  ROM: values driven on DUT pins
- vec_oe  input  NUM_PINS  ROM: 1 = pin driven by tester
- vec_expect  input  NUM_PINS  ROM: expected DUT pin levels
- vec_mask  input  NUM_PINS  ROM: 1 = pin compared
- vec_last  input  1  ROM: this is the bank's last vector
- pin_out  output  NUM_PINS  tester drive values
- pin_oe  output  NUM_PINS  tester drive enables
- pin_in  input  NUM_PINS  sampled DUT pin levels (already synchronised)
- busy  output  1  test in progress
- done  output  1  result valid; held until next start or abort
- pass  output  1  all compared vectors matched (valid when done)
- unsupported  output  1  ic_code not in table (valid when done)
- fail_index  output  VEC_AW  index of first failing vector (valid when done && !pass && !unsupported)

Behaviour:
- Reset (iRST=1 at posedge): state IDLE; all outputs 0, including pin_oe, pin_out, vec_addr, fail_index. ic_read edge detector register cleared.
- Priority each cycle: iRST > abort > start > normal progress.
- start = ic_read & ~ic_read_q, where ic_read_q is registered every cycle. Holding ic_read high does not retrigger. start outside IDLE/DONE is ignored.
- Bank decode: 7400->0, 7402->1, 7404->2, 7408->3, 7432->4, 7486->5. Any other code is unsupported.
- States:
  - IDLE: busy=0, pin_oe=0. On start -> DECODE; clear done/pass/unsupported/fail_index; busy=1.
  - DECODE (1 cycle): unsupported -> DONE with unsupported=1, pass=0. Otherwise latch bank, idx=0, fail flag=0 -> FETCH.
  - FETCH: vec_addr={bank,idx} -> WAIT_ROM. ROM has a 1-cycle read latency.
  - WAIT_ROM: capture vec_drive/oe/expect/mask/last into registers -> APPLY.
  - APPLY: pin_out/pin_oe <= captured values; settle counter <= SETTLE_CYCLES-1 -> SETTLE.
  - SETTLE: decrement; at 0 -> SAMPLE.
  - SAMPLE: mismatch = |((pin_in ^ expect) & mask). On first mismatch, fail_index<=idx and fail flag<=1. If last or idx==2^VEC_AW-1 -> DONE; else idx+1 -> FETCH.
  - DONE: pin_oe=0, busy=0, done=1, pass=~fail flag & ~unsupported. On start -> DECODE, same clears as IDLE.
- Pins keep the previous vector during FETCH/WAIT_ROM; no intermediate tristate.
- Per-vector cost is SETTLE_CYCLES+4 cycles.
- Start edge to done for an unsupported code: 2 cycles (DECODE, then DONE registered).
- abort in any state: next cycle IDLE, pin_oe=0, busy/done/pass/unsupported=0.
- idx does not wrap: the 2^VEC_AW-th vector terminates the test even if vec_last=0.

Optional Feature:
- STOP_ON_FAIL_EN
  - Defined: SAMPLE with a mismatch goes directly to DONE (pass=0, fail_index=idx); remaining vectors are skipped.
  - Undefined: all vectors run; fail_index holds the first failure.

Test Plan:
- SETTLE_CYCLES=4, ic_code=16'h7400, ROM bank 0 has 4 vectors (last on idx 3), pin_in model matches expect -> vec_addr steps 0x00..0x03; done=1, pass=1 at 4*8+1 cycles after start; pin_oe=0 in DONE.
- ic_code=16'h7408, pin_in forced wrong on a masked pin at idx 2 and idx 3 -> done=1, pass=0, fail_index=2; all 4 vectors run (macro undefined).
- ic_code=16'h7499 -> done=1, unsupported=1, pass=0 two cycles after the ic_read edge; vec_addr never changes; pin_oe stays 0.
- abort pulsed mid-SETTLE of idx 1 -> next cycle busy=0, done=0, pin_oe=0; a new ic_read edge restarts from idx 0.
- ic_read held high 100 cycles after DONE -> no restart. ic_read low then high -> new test. iRST mid-test -> all outputs 0 next cycle.
- STOP_ON_FAIL_EN defined, mismatch at idx 1 of 4 -> DONE immediately after SAMPLE of idx 1; fail_index=1; vec_addr never reaches idx 2.
